// File: rtl/tlc_pkg.sv
// Shared constants for the traffic-light controller input front end.
//   DEF_NUM_CH, DEF_SYNC_STAGES, DEF_DEBOUNCE_CYCLES : default sizing of input_conditioner
//   CH_SENSOR, CH_WALK, CH_PROG, CH_SPARE            : named channel indices
//   cnt_width()                                      : debounce counter width for a cycle count
package tlc_pkg;

    localparam int unsigned DEF_NUM_CH          = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

    localparam int unsigned CH_SENSOR = 0;
    localparam int unsigned CH_WALK   = 1;
    localparam int unsigned CH_PROG   = 2;
    localparam int unsigned CH_SPARE  = 3;

    // Enough bits to hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Signal bundle between the input conditioner and its user.
//   raw_in      : asynchronous external inputs, one bit per channel
//   latch_clr   : synchronous per-channel clear of latch_out
//   level_out   : synchronized, debounced level
//   rise_pulse  : one-cycle pulse per committed 0->1
//   fall_pulse  : one-cycle pulse per committed 1->0
//   latch_out   : sticky request flag, set by a rise
//   any_latched : OR of latch_out
// master = the side driving raw_in/latch_clr; slave = the conditioner.
interface input_conditioner_if
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH
) ();

    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] latch_clr;
    logic [NUM_CH-1:0] level_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic [NUM_CH-1:0] latch_out;
    logic              any_latched;

    modport master (
        output raw_in, latch_clr,
        input  level_out, rise_pulse, fall_pulse, latch_out, any_latched
    );

    modport slave (
        input  raw_in, latch_clr,
        output level_out, rise_pulse, fall_pulse, latch_out, any_latched
    );

endinterface

// File: rtl/input_conditioner_ch.sv
// One input channel: synchronizer chain, debounce counter, edge pulses and sticky latch.
//   clk, reset  : clock, asynchronous active-high reset
//   raw_in      : asynchronous input bit
//   latch_clr   : synchronous clear of latch_out (a coincident rise wins)
//   level_out   : debounced level
//   rise_pulse  : registered pulse on a committed 0->1
//   fall_pulse  : registered pulse on a committed 1->0
//   latch_out   : sticky flag set by a rise
module input_conditioner_ch
    import tlc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    input  logic latch_clr,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic latch_out
);

    localparam int unsigned   CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic [CntW-1:0]        cnt_q;
    logic [CntW-1:0]        cnt_d;
    logic                   commit;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   latch_q;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronized input disagrees with the committed level,
    // so any bounce back to the committed level restarts the debounce window.
    always_comb begin
        commit = 1'b0;
        cnt_d  = cnt_q;
        if (sync_last == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            commit = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
            cnt_q  <= cnt_d;
            if (commit) begin
                level_q <= sync_last;
            end
            rise_q <= commit & sync_last;
            fall_q <= commit & ~sync_last;
            // Set has priority over clear so a request arriving with a clear is not lost.
            if (commit && sync_last) begin
                latch_q <= 1'b1;
            end else if (latch_clr) begin
                latch_q <= 1'b0;
            end
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign latch_out  = latch_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: NUM_CH independent input_conditioner_ch instances
// plus the any_latched summary.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : input_conditioner_if slave (raw_in, latch_clr in; level/pulses/latch out)
module input_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input_conditioner_if.slave   bus
);

    logic [NUM_CH-1:0] level_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic [NUM_CH-1:0] latch_out;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        input_conditioner_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .raw_in     (bus.raw_in[i]),
            .latch_clr  (bus.latch_clr[i]),
            .level_out  (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .latch_out  (latch_out[i])
        );
    end

    assign bus.level_out   = level_out;
    assign bus.rise_pulse  = rise_pulse;
    assign bus.fall_pulse  = fall_pulse;
    assign bus.latch_out   = latch_out;
    assign bus.any_latched = |latch_out;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock).
// A window model (a level flips once the last DEBOUNCE_CYCLES synchronized samples all
// disagree with it) is checked every cycle; directed checks pin literal values.
module tb_input_conditioner;
    import tlc_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned SS  = 2;
    localparam int unsigned DB  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    input_conditioner_if #(.NUM_CH(NCH)) bus ();

    input_conditioner #(
        .NUM_CH          (NCH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [NCH-1:0] got,
                         input logic [NCH-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- model ----------------
    // hist[k] = raw_in sampled k edges ago; the decision at an edge sees the samples
    // SS..SS+DB-1 edges old (the synchronizer delay).
    logic [NCH-1:0] hist [SS+DB];
    logic [NCH-1:0] m_level = '0;
    logic [NCH-1:0] m_rise  = '0;
    logic [NCH-1:0] m_fall  = '0;
    logic [NCH-1:0] m_latch = '0;

    initial begin
        logic [NCH-1:0] raw;
        logic [NCH-1:0] clr;
        bit             flip;
        for (int k = 0; k < SS + DB; k++) hist[k] = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int k = 0; k < SS + DB; k++) hist[k] = '0;
                m_level = '0;
                m_rise  = '0;
                m_fall  = '0;
                m_latch = '0;
            end else begin
                raw = bus.raw_in;
                clr = bus.latch_clr;
                for (int k = SS + DB - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = raw;
                for (int ch = 0; ch < NCH; ch++) begin
                    flip = 1'b1;
                    for (int k = SS; k < SS + DB; k++) begin
                        if (hist[k][ch] == m_level[ch]) flip = 1'b0;
                    end
                    m_rise[ch] = 1'b0;
                    m_fall[ch] = 1'b0;
                    if (flip) begin
                        m_level[ch] = ~m_level[ch];
                        if (m_level[ch]) m_rise[ch] = 1'b1;
                        else             m_fall[ch] = 1'b1;
                    end
                    if (m_rise[ch])   m_latch[ch] = 1'b1;
                    else if (clr[ch]) m_latch[ch] = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("model level_out",   bus.level_out,   m_level);
            check("model rise_pulse",  bus.rise_pulse,  m_rise);
            check("model fall_pulse",  bus.fall_pulse,  m_fall);
            check("model latch_out",   bus.latch_out,   m_latch);
            check("model any_latched", NCH'(bus.any_latched), NCH'(|m_latch));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.raw_in    = '1;
        bus.latch_clr = '0;

        // Reset held with all inputs high: everything stays 0.
        repeat (3) begin
            @(negedge clk);
            check("reset level_out",  bus.level_out, '0);
            check("reset latch_out",  bus.latch_out, '0);
            check("reset pulses",     bus.rise_pulse | bus.fall_pulse, '0);
            check("reset any_latched", NCH'(bus.any_latched), '0);
        end
        bus.raw_in = '0;
        reset      = 1'b0;
        tick(3);

        // Walk input held high: commits on the 6th edge.
        bus.raw_in[CH_WALK] = 1'b1;
        tick(5);
        check("walk level before commit", NCH'(bus.level_out[CH_WALK]), '0);
        tick(1);
        check("walk level at commit", NCH'(bus.level_out[CH_WALK]), 1);
        check("walk rise at commit",  bus.rise_pulse, 4'b0010);
        check("walk latch",           NCH'(bus.latch_out[CH_WALK]), 1);
        check("walk any_latched",     NCH'(bus.any_latched), 1);
        tick(1);
        check("walk rise one cycle",  bus.rise_pulse, '0);
        check("walk level held",      NCH'(bus.level_out[CH_WALK]), 1);

        // Sensor glitch of 3 cycles is rejected.
        bus.raw_in[CH_SENSOR] = 1'b1;
        tick(3);
        bus.raw_in[CH_SENSOR] = 1'b0;
        repeat (8) begin
            tick(1);
            check("glitch level", NCH'(bus.level_out[CH_SENSOR]), '0);
            check("glitch rise",  NCH'(bus.rise_pulse[CH_SENSOR]), '0);
            check("glitch latch", NCH'(bus.latch_out[CH_SENSOR]), '0);
        end

        // One-cycle clear of the walk latch.
        bus.latch_clr[CH_WALK] = 1'b1;
        tick(1);
        bus.latch_clr[CH_WALK] = 1'b0;
        check("clr walk latch",       bus.latch_out, '0);
        check("clr any_latched",      NCH'(bus.any_latched), '0);
        check("clr keeps walk level", bus.level_out, 4'b0010);

        // Clear coinciding with the prog rise commit: set wins.
        bus.raw_in[CH_PROG] = 1'b1;
        tick(5);
        bus.latch_clr[CH_PROG] = 1'b1;
        tick(1);
        bus.latch_clr[CH_PROG] = 1'b0;
        check("set-wins latch", bus.latch_out, 4'b0100);
        check("set-wins rise",  bus.rise_pulse, 4'b0100);
        tick(2);

        // Prog falls: level drops on the 6th edge, latch untouched.
        bus.raw_in[CH_PROG] = 1'b0;
        tick(5);
        check("prog level before fall", bus.level_out, 4'b0110);
        tick(1);
        check("prog level after fall", bus.level_out, 4'b0010);
        check("prog fall pulse",       bus.fall_pulse, 4'b0100);
        check("prog latch kept",       bus.latch_out, 4'b0100);
        tick(1);
        check("prog fall one cycle",   bus.fall_pulse, '0);

        // Spare high, reset mid-debounce after 4 edges.
        bus.raw_in[CH_SPARE] = 1'b1;
        tick(4);
        #2 reset = 1'b1;
        #1;
        check("async reset level", bus.level_out, '0);
        check("async reset latch", bus.latch_out, '0);
        check("async reset any",   NCH'(bus.any_latched), '0);
        @(negedge clk);
        reset = 1'b0;
        tick(5);
        check("post-reset level before commit", bus.level_out, '0);
        check("post-reset rise before commit",  bus.rise_pulse, '0);
        tick(1);
        check("post-reset level", bus.level_out, 4'b1010);
        check("post-reset rise",  bus.rise_pulse, 4'b1010);
        check("post-reset latch", bus.latch_out, 4'b1010);
        tick(1);
        check("post-reset rise one cycle", bus.rise_pulse, '0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent input channels, range 1..16.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of each synchronizer chain, minimum 2.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to commit a level change, minimum 1.
REQ-004 The block SHALL have port clk  input  1: single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 The block SHALL have port raw_in  input  NUM_CH: asynchronous external inputs (sensor, walk, reprogram and similar).
REQ-007 The block SHALL have port latch_clr  input  NUM_CH: synchronous per-channel clear of latch_out.
REQ-008 The block SHALL have port level_out  output  NUM_CH: synchronized, debounced level.
REQ-009 The block SHALL have port rise_pulse  output  NUM_CH: one-cycle pulse on each committed 0->1 of level_out.
REQ-010 The block SHALL have port fall_pulse  output  NUM_CH: one-cycle pulse on each committed 1->0 of level_out.
REQ-011 The block SHALL have port latch_out  output  NUM_CH: sticky request flag, set by a rise and held until cleared.
REQ-012 The block SHALL have port any_latched  output  1: OR-reduction of latch_out.

Function
REQ-013 Each channel SHALL pass raw_in[i] through SYNC_STAGES flip-flops in series; sync_q[i] is the last stage.
REQ-014 Per channel, a counter of width clog2(DEBOUNCE_CYCLES+1) SHALL clear to 0 on any edge where sync_q equals level_out.
REQ-015 When sync_q differs from level_out and the counter equals DEBOUNCE_CYCLES-1, level_out SHALL take sync_q and the counter SHALL clear; otherwise the counter SHALL increment.
REQ-016 Latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges, from the first edge sampling a new stable raw_in to the edge updating level_out.
REQ-017 A raw_in excursion shorter than DEBOUNCE_CYCLES cycles at sync_q SHALL leave level_out, rise_pulse, fall_pulse and latch_out unchanged.
REQ-018 rise_pulse[i] SHALL be registered and high for exactly the one cycle following the edge at which level_out[i] commits 0->1; fall_pulse[i] likewise for 1->0.
REQ-019 latch_out[i] SHALL set on the same edge that asserts rise_pulse[i], and SHALL clear on an edge with latch_clr[i]=1.
REQ-020 If a rise commit and latch_clr[i] coincide on the same edge, set SHALL win and latch_out[i] SHALL be 1.
REQ-021 latch_clr[i] SHALL have no effect on level_out, the pulses or the counters.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled per REQ-013..REQ-020.
REQ-023 any_latched SHALL be combinational from the latch_out registers.

Reset
REQ-024 While reset=1, all synchronizer stages, counters, level_out, rise_pulse, fall_pulse and latch_out SHALL be 0, asynchronously and without waiting for clk.
REQ-025 A reset asserted mid-debounce SHALL discard the partial count.
REQ-026 After reset deassertion, a held-high input SHALL need the full SYNC_STAGES+DEBOUNCE_CYCLES edges to commit, and SHALL then produce a rise_pulse.

Structure
REQ-027 The shared package tlc_pkg SHALL hold the default constants for NUM_CH, SYNC_STAGES and DEBOUNCE_CYCLES, plus named channel indices (CH_SENSOR=0, CH_WALK=1, CH_PROG=2, CH_SPARE=3).
REQ-028 The block SHALL instantiate the single-channel sub-module input_conditioner_ch NUM_CH times in a generate loop; the top level SHALL only add any_latched.

Verification (NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, clk period 10 ns)
REQ-029 Bench SHALL check: reset=1 with raw_in=4'b1111 -> all outputs 0 throughout reset.
REQ-030 Bench SHALL check: raw_in[1] held high from edge N -> level_out[1]=1 after edge N+5, rise_pulse[1] high exactly one cycle, latch_out[1]=1, any_latched=1.
REQ-031 Bench SHALL check: raw_in[0] high for 3 cycles then low -> level_out[0], pulses and latch_out[0] stay 0.
REQ-032 Bench SHALL check: latch_clr[1] for one cycle -> latch_out[1]=0 after the next edge; latch_clr[2] on the same edge as the ch2 rise commit -> latch_out[2]=1.
REQ-033 Bench SHALL check: raw_in[3] high, reset pulsed after 4 edges -> outputs 0 immediately; after release, rise only after 6 further edges.
REQ-034 Bench SHALL check: a committed-high channel driven low for 6+ edges -> level_out=0, fall_pulse high one cycle, latch_out unchanged.
